// File: rtl/ijtc_gshare_predictor_pkg.sv
// ----------------------------------------------------------------------------
// ijtc_gshare_predictor_pkg
//   Shared constants for the indirect-jump target cache (IJTC) predictor.
//   Default geometry, word helpers and the checkpoint width used by the
//   frontend/backend plumbing that carries GHR snapshots.
// ----------------------------------------------------------------------------
package ijtc_gshare_predictor_pkg;

    localparam int unsigned DEF_FETCH_WIDTH = 4;
    localparam int unsigned DEF_IDX_LEN     = 8;
    localparam int unsigned DEF_GHR_LEN     = 8;
    localparam int unsigned DEF_TAG_LEN     = 10;

    // Checkpoint width equals GHR length.
    localparam int unsigned IJTC_CHECKPOINT = DEF_GHR_LEN;
    localparam int unsigned SINGLE_WORD     = 32;
    localparam logic [31:0] ZEROWORD        = 32'h0;

    // Byte offset of the k-th word after a base address.
    function automatic logic [31:0] word_ofs(input int unsigned k);
        return 32'(4 * k);
    endfunction

endpackage

// File: rtl/ijtc_gshare_predictor_if.sv
// ----------------------------------------------------------------------------
// ijtc_gshare_predictor_if
//   Fetch-side lookup, speculative-history and backend-repair signals of the
//   IJTC predictor. master = frontend/backend driver, slave = predictor.
//   Lookup : inst_req, inst_index_ok, pc_i, fallthru_i
//   Result : pred_dest_o, pred_hit_o, checkpoint_o (per slot, flattened)
//   Spec   : spec_valid_i, spec_taken_i
//   Repair : repair_valid_i, repair_ckpt_i, repair_pc_i, repair_taken_i,
//            repair_ijr_i, repair_dest_i
// ----------------------------------------------------------------------------
interface ijtc_gshare_predictor_if #(
    parameter int unsigned FETCH_WIDTH = 4,
    parameter int unsigned GHR_LEN     = 8
);
    logic                           inst_req;
    logic                           inst_index_ok;
    logic [31:0]                    pc_i;
    logic [31:0]                    fallthru_i;
    logic [FETCH_WIDTH*32-1:0]      pred_dest_o;
    logic [FETCH_WIDTH-1:0]         pred_hit_o;
    logic [FETCH_WIDTH*GHR_LEN-1:0] checkpoint_o;
    logic                           spec_valid_i;
    logic                           spec_taken_i;
    logic                           repair_valid_i;
    logic [GHR_LEN-1:0]             repair_ckpt_i;
    logic [31:0]                    repair_pc_i;
    logic                           repair_taken_i;
    logic                           repair_ijr_i;
    logic [31:0]                    repair_dest_i;

    modport master (
        output inst_req, inst_index_ok, pc_i, fallthru_i,
        output spec_valid_i, spec_taken_i,
        output repair_valid_i, repair_ckpt_i, repair_pc_i, repair_taken_i,
        output repair_ijr_i, repair_dest_i,
        input  pred_dest_o, pred_hit_o, checkpoint_o
    );

    modport slave (
        input  inst_req, inst_index_ok, pc_i, fallthru_i,
        input  spec_valid_i, spec_taken_i,
        input  repair_valid_i, repair_ckpt_i, repair_pc_i, repair_taken_i,
        input  repair_ijr_i, repair_dest_i,
        output pred_dest_o, pred_hit_o, checkpoint_o
    );
endinterface

// File: rtl/ijtc_gshare_predictor_table.sv
// ----------------------------------------------------------------------------
// ijtc_table
//   ENTRIES x {valid, tag, target} flop array for the IJTC predictor.
//   NUM_RD asynchronous read ports, one synchronous write port. Only the
//   valid bits are cleared by reset; tag/target contents are don't-care
//   while invalid.
//   clk, rst       : clock, synchronous active-low reset
//   rd_idx         : per-port read index
//   rd_valid/tag/dest : per-port combinational read data
//   wr_en/idx/tag/dest : write port (sets valid)
// ----------------------------------------------------------------------------
module ijtc_table #(
    parameter int unsigned NUM_RD  = 4,
    parameter int unsigned IDX_LEN = 8,
    parameter int unsigned TAG_LEN = 10
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_RD-1:0][IDX_LEN-1:0]   rd_idx,
    output logic [NUM_RD-1:0]                rd_valid,
    output logic [NUM_RD-1:0][TAG_LEN-1:0]   rd_tag,
    output logic [NUM_RD-1:0][31:0]          rd_dest,
    input  logic                             wr_en,
    input  logic [IDX_LEN-1:0]               wr_idx,
    input  logic [TAG_LEN-1:0]               wr_tag,
    input  logic [31:0]                      wr_dest
);
    localparam int unsigned ENTRIES = 2 ** IDX_LEN;

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_LEN-1:0] tag_q  [ENTRIES];
    logic [31:0]        dest_q [ENTRIES];

    always_ff @(posedge clk) begin
        if (!rst)
            valid_q <= '0;
        else if (wr_en)
            valid_q[wr_idx] <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_q[wr_idx]  <= wr_tag;
            dest_q[wr_idx] <= wr_dest;
        end
    end

    // Async reads: a same-cycle write is only visible after the edge, so the
    // lookup registers naturally capture pre-write contents.
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        assign rd_valid[k] = valid_q[rd_idx[k]];
        assign rd_tag[k]   = tag_q[rd_idx[k]];
        assign rd_dest[k]  = dest_q[rd_idx[k]];
    end

endmodule

// File: rtl/ijtc_gshare_predictor.sv
// ----------------------------------------------------------------------------
// ijtc_gshare_predictor
//   Tagged gshare indirect-jump (j*r $1-30) target predictor. Looks up every
//   slot of a fetch block with the current GHR, registers per-slot targets,
//   hit flags and the GHR checkpoint. Keeps the speculative GHR, restores it
//   on backend repair and trains the table from repaired indirect jumps.
//   clk, rst : clock, synchronous active-low reset
//   bus      : ijtc_gshare_predictor_if.slave (lookup/result/spec/repair)
// ----------------------------------------------------------------------------
module ijtc_gshare_predictor
    import ijtc_gshare_predictor_pkg::*;
#(
    parameter int unsigned FETCH_WIDTH = DEF_FETCH_WIDTH,
    parameter int unsigned IDX_LEN     = DEF_IDX_LEN,
    parameter int unsigned GHR_LEN     = DEF_GHR_LEN,
    parameter int unsigned TAG_LEN     = DEF_TAG_LEN
) (
    input  logic                      clk,
    input  logic                      rst,
    ijtc_gshare_predictor_if.slave    bus
);
    localparam int unsigned LOG_FW = $clog2(FETCH_WIDTH);
    localparam int unsigned TAG_LO = IDX_LEN + 2;
    localparam int unsigned TAG_HI = IDX_LEN + TAG_LEN + 1;

    logic [GHR_LEN-1:0]                   ghr_q;
    logic                                 fire;
    logic [FETCH_WIDTH-1:0][31:0]         slot_pc;
    logic [FETCH_WIDTH-1:0][IDX_LEN-1:0]  rd_idx;
    logic [FETCH_WIDTH-1:0]               rd_valid;
    logic [FETCH_WIDTH-1:0][TAG_LEN-1:0]  rd_tag;
    logic [FETCH_WIDTH-1:0][31:0]         rd_dest;
    logic [FETCH_WIDTH-1:0][31:0]         nxt_dest;
    logic [FETCH_WIDTH-1:0]               nxt_hit;
    logic [FETCH_WIDTH-1:0][31:0]         dest_q;
    logic [FETCH_WIDTH-1:0]               hit_q;
    logic [FETCH_WIDTH-1:0][GHR_LEN-1:0]  ckpt_q;
    logic                                 wr_en;
    logic [IDX_LEN-1:0]                   wr_idx;
    logic                                 unused_bits;

    assign fire = bus.inst_req & bus.inst_index_ok;

    for (genvar k = 0; k < FETCH_WIDTH; k++) begin : g_slot
        localparam logic [LOG_FW-1:0] KB = LOG_FW'(k);
        logic tag_eq;

        assign slot_pc[k] = {bus.pc_i[31:2+LOG_FW], KB, 2'b00};
        assign rd_idx[k]  = slot_pc[k][IDX_LEN+1:2] ^ IDX_LEN'(ghr_q);
        assign tag_eq     = rd_tag[k] == slot_pc[k][TAG_HI:TAG_LO];
        assign nxt_hit[k] = rd_valid[k] & tag_eq;

        // Miss target is pc+8; the last two slots spill into the next block,
        // which need not be contiguous, so they are built from fallthru_i.
        if (k >= FETCH_WIDTH - 2) begin : g_spill
            assign nxt_dest[k] = nxt_hit[k] ? rd_dest[k]
                               : bus.fallthru_i + word_ofs(k + 2 - FETCH_WIDTH);
        end else begin : g_inblk
            assign nxt_dest[k] = nxt_hit[k] ? rd_dest[k] : slot_pc[k] + 32'd8;
        end
    end

    assign wr_en  = bus.repair_valid_i & bus.repair_ijr_i;
    assign wr_idx = bus.repair_pc_i[IDX_LEN+1:2] ^ IDX_LEN'(bus.repair_ckpt_i);

    ijtc_table #(
        .NUM_RD  (FETCH_WIDTH),
        .IDX_LEN (IDX_LEN),
        .TAG_LEN (TAG_LEN)
    ) u_table (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (rd_idx),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_dest  (rd_dest),
        .wr_en    (wr_en),
        .wr_idx   (wr_idx),
        .wr_tag   (bus.repair_pc_i[TAG_HI:TAG_LO]),
        .wr_dest  (bus.repair_dest_i)
    );

    // Repair overrides a same-cycle speculative shift.
    always_ff @(posedge clk) begin
        if (!rst)
            ghr_q <= '0;
        else if (bus.repair_valid_i)
            ghr_q <= {bus.repair_ckpt_i[GHR_LEN-2:0], bus.repair_taken_i};
        else if (bus.spec_valid_i)
            ghr_q <= {ghr_q[GHR_LEN-2:0], bus.spec_taken_i};
    end

    // Results hold until the next accepted lookup.
    always_ff @(posedge clk) begin
        if (!rst) begin
            dest_q <= '0;
            hit_q  <= '0;
            ckpt_q <= '0;
        end else if (fire) begin
            dest_q <= nxt_dest;
            hit_q  <= nxt_hit;
            ckpt_q <= {FETCH_WIDTH{ghr_q}};
        end
    end

    assign bus.pred_dest_o  = dest_q;
    assign bus.pred_hit_o   = hit_q;
    assign bus.checkpoint_o = ckpt_q;

    assign unused_bits = ^{bus.pc_i[1:0], bus.repair_pc_i[1:0], bus.repair_pc_i[31:TAG_HI+1]};

endmodule
